// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch-stage program counter. Chooses each cycle's
// next PC (sequential, branch, jump or hold), arbitrates redirect sources,
// honours stalls, flags fetch flushes and traps misaligned redirect targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Halt,
  output logic [31:0] PCResult,
  output logic [31:0] PCPlus4,
  output logic        FetchValid,
  output logic        FlushIF,
  output logic        MisalignErr,
  output logic        Halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } state_t;

  // Boot counter value at which the final idle edge occurs.
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [3:0]  boot_cnt, boot_cnt_next;
  logic        flush, flush_next;
  logic        misalign, misalign_next;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc + 32'd4;

  // Next-state / next-PC selection with redirect > halt > stall > sequential priority.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next    = state;
    pc_next       = pc;
    boot_cnt_next = boot_cnt;
    flush_next    = 1'b0;
    misalign_next = misalign;
    case (state)
      BOOT: begin
        boot_cnt_next = boot_cnt + 4'd1;
        if (boot_cnt == BOOT_LAST) state_next = RUN;
      end
      RUN: begin
        // Branch is the older instruction, so it beats a jump; any redirect
        // means a same-cycle halt was fetched on the wrong path.
        if (BranchTaken) begin
          if (BranchTarget[1:0] != 2'b00) begin
            state_next    = ERROR;
            misalign_next = 1'b1;
          end else begin
            pc_next    = BranchTarget;
            flush_next = 1'b1;
          end
        end else if (Jump) begin
          if (JumpTarget[1:0] != 2'b00) begin
            state_next    = ERROR;
            misalign_next = 1'b1;
          end else begin
            pc_next    = JumpTarget;
            flush_next = 1'b1;
          end
        end else if (Halt) begin
          state_next = HALTED;
        end else if (!Stall) begin
          pc_next = pc_plus4;
        end
      end
      default: ; // HALTED and ERROR are terminal until reset
    endcase
  end

  // State registers, cleared asynchronously by Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      boot_cnt <= 4'd0;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state    <= state_next;
      pc       <= pc_next;
      boot_cnt <= boot_cnt_next;
      flush    <= flush_next;
      misalign <= misalign_next;
    end
  end

  assign PCResult    = pc;
  assign PCPlus4     = pc_plus4;
  assign FetchValid  = (state == RUN);
  assign FlushIF     = flush;
  assign MisalignErr = misalign;
  assign Halted      = (state == HALTED) || (state == ERROR);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          BOOT_CYCLES = 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'h0;
  logic        Jump = 1'b0;
  logic [31:0] JumpTarget = 32'h0;
  logic        Halt = 1'b0;
  logic [31:0] PCResult, PCPlus4;
  logic        FetchValid, FlushIF, MisalignErr, Halted;

  int checks = 0;
  int errors = 0;

  // Behavioural model: idle edges still to burn, whether fetching has stopped,
  // whether the stop was caused by a bad target, and the pending flush.
  logic [31:0] m_pc;
  int          m_boot_left;
  bit          m_stopped;
  bit          m_err;
  bit          m_flush;

  pc_sequencer #(.RESET_PC(RESET_PC), .BOOT_CYCLES(BOOT_CYCLES)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .Halt(Halt),
    .PCResult(PCResult), .PCPlus4(PCPlus4), .FetchValid(FetchValid),
    .FlushIF(FlushIF), .MisalignErr(MisalignErr), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},       PCResult,           m_pc);
    check({tag, ".pc4"},      PCPlus4,            m_pc + 32'd4);
    check({tag, ".valid"},    32'(FetchValid),    32'(m_boot_left == 0 && !m_stopped));
    check({tag, ".flush"},    32'(FlushIF),       32'(m_flush));
    check({tag, ".misalign"}, 32'(MisalignErr),   32'(m_err));
    check({tag, ".halted"},   32'(Halted),        32'(m_stopped));
  endtask

  function automatic void model_reset();
    m_pc        = RESET_PC;
    m_boot_left = BOOT_CYCLES;
    m_stopped   = 1'b0;
    m_err       = 1'b0;
    m_flush     = 1'b0;
  endfunction

  // Redirect to tgt, or stop with an error if it is not word-aligned.
  function automatic void model_redirect(input logic [31:0] tgt);
    if (tgt % 4 != 0) begin
      m_stopped = 1'b1;
      m_err     = 1'b1;
    end else begin
      m_pc    = tgt;
      m_flush = 1'b1;
    end
  endfunction

  function automatic void model_edge();
    m_flush = 1'b0;
    if (m_boot_left > 0)       m_boot_left--;
    else if (m_stopped)        ;
    else if (BranchTaken)      model_redirect(BranchTarget);
    else if (Jump)             model_redirect(JumpTarget);
    else if (Halt)             m_stopped = 1'b1;
    else if (!Stall)           m_pc = m_pc + 32'd4;
  endfunction

  // Apply one cycle of inputs, clock it, then compare just after the edge.
  task automatic step(input string tag, input bit st, input bit bt, input logic [31:0] btt,
                      input bit j, input logic [31:0] jt, input bit h);
    Stall = st; BranchTaken = bt; BranchTarget = btt;
    Jump = j; JumpTarget = jt; Halt = h;
    @(posedge Clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  // Assert Reset between edges; outputs must clear before any clock edge.
  task automatic reset_pulse(input string tag);
    Reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_all("por");
    @(negedge Clk);
    Reset = 1'b0;

    // Boot then sequential fetch 0x0, 0x4, 0x8, 0xC, 0x10.
    idle("boot_seq", 5);
    check("at_0x10", PCResult, 32'h10);

    // Stall holds, then a branch overrides the stall.
    for (int i = 0; i < 3; i++) step("stall", 1, 0, 32'h0, 0, 32'h0, 0);
    step("stall_branch", 1, 1, 32'h100, 0, 32'h0, 0);
    idle("after_branch", 2);

    // Branch beats jump beats halt.
    step("prio", 0, 1, 32'h200, 1, 32'h300, 1);
    step("prio_next", 0, 0, 32'h0, 1, 32'h400, 0); // back-to-back redirect
    idle("prio_run", 1);

    // 32-bit wrap.
    step("wrap_jump", 0, 0, 32'h0, 1, 32'hFFFF_FFF8, 0);
    idle("wrap", 2);
    check("wrap_zero", PCResult, 32'h0);

    // Misaligned jump at PC 0x40 traps; later inputs are ignored.
    step("to_0x40", 0, 0, 32'h0, 1, 32'h40, 0);
    step("misalign", 0, 0, 32'h0, 1, 32'h402, 0);
    step("err_ignore", 0, 1, 32'h800, 1, 32'h900, 0);
    idle("err_hold", 2);
    reset_pulse("rst_err");
    idle("reboot1", 3);

    // Halt at 0x20 freezes; mid-cycle reset restarts boot.
    step("to_0x20", 0, 0, 32'h0, 1, 32'h20, 0);
    step("halt", 0, 0, 32'h0, 0, 32'h0, 1);
    step("halt_ignore", 0, 1, 32'h500, 0, 32'h0, 0);
    idle("halt_hold", 2);
    reset_pulse("rst_halt");
    idle("reboot2", 3);

    // Randomized traffic with occasional misaligned targets and resets.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] bt_t, j_t;
      bt_t = {$urandom(), 2'b00} >> 0;
      bt_t[1:0] = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      j_t = $urandom();
      j_t[1:0] = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 59) == 0) reset_pulse("rnd_rst");
      else step("rnd",
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 5) == 0, bt_t,
                $urandom_range(0, 5) == 0, j_t,
                $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
